cc_logic: RTL and testbench
===========================

CC_LOGIC -- requirements
Module: cc_logic

Interface
- REQ-001: Parameter WIDTH SHALL be an integer, default 8, giving the data width of d_in, d_out and d_next.
- REQ-002: Port clk SHALL be an input, 1 bit wide, and is the single clock; all sequential elements are rising-edge triggered.
- REQ-003: Port reset SHALL be an input, 1 bit wide, reset is synchronous and active-high.
- REQ-004: Port op SHALL be an input, 3 bits wide, carrying the operation code.
- REQ-005: Port shamt SHALL be an input, 2 bits wide, giving the shift amount 0..3.
- REQ-006: Port d_in SHALL be an input, WIDTH bits wide, carrying parallel load data.
- REQ-007: Port d_out SHALL be an input, WIDTH bits wide, carrying the current shifter register value.
- REQ-008: Port d_next SHALL be an output, WIDTH bits wide, carrying the next register value.

Function
- REQ-009: op 3'b000 (NOP) SHALL give d_next = d_out.
- REQ-010: op 3'b001 (LOAD) SHALL give d_next = d_in, with shamt ignored.
- REQ-011: op 3'b010 (LSL) SHALL give d_next = d_out shifted left by shamt, zero-filled from the LSB.
- REQ-012: op 3'b011 (LSR) SHALL give d_next = d_out shifted right by shamt, zero-filled from the MSB.
- REQ-013: op 3'b100 (ASR) SHALL give d_next = d_out shifted right by shamt, filled with d_out[WIDTH-1].
- REQ-014: For op 3'b010, 3'b011 and 3'b100, shamt 2'b00 SHALL give d_next = d_out.
- REQ-015: op 3'b101, 3'b110 and 3'b111 are reserved and SHALL give d_next = d_out (hold); X/Z SHALL never be driven.
- REQ-016: Bits shifted out SHALL be discarded; there is no wrap-around and no carry or status output.
- REQ-017: Without the configuration macro, d_next SHALL be purely combinational from op, shamt, d_in and d_out, with zero latency and no dependence on clk or reset.

Reset
- REQ-018: In registered mode (REQ-020), reset asserted at a clk rising edge SHALL load the output register with all zeros, overriding any op.
- REQ-019: In combinational mode, reset SHALL have no effect on d_next.

Configuration
- REQ-020: With CC_LOGIC_REG_OUT_EN defined, d_next SHALL be driven from a register that captures the REQ-009..REQ-015 result on each clk rising edge, giving 1-cycle latency. The register reset value is 0; reset mid-operation clears it on that edge, and normal capture resumes on the next edge after reset deasserts.
- REQ-021: With CC_LOGIC_REG_OUT_EN undefined, the behaviour SHALL be as in REQ-017, and the clk and reset ports SHALL remain present but unused.

Structure
- REQ-022: A shared package cc_pkg SHALL hold the op-code constants: OP_NOP=000, OP_LOAD=001, OP_LSL=010, OP_LSR=011, OP_ASR=100.
- REQ-023: The shift datapath SHALL be one sub-module, cc_shift_unit, taking a direction, an arithmetic flag, shamt and data, and returning the shifted data.
- REQ-024: The op decode and the optional output register SHALL reside in cc_logic.

Verification
- REQ-025: op=001, shamt=01, d_in=8'h5C, d_out=8'h00 -> d_next=8'h5C.
- REQ-026: op=010, shamt=10: d_out=8'h4D -> d_next=8'h34; d_out=8'h8C -> d_next=8'h30.
- REQ-027: op=011, shamt=01: d_out=8'hCD -> d_next=8'h66; d_out=8'h53 -> d_next=8'h29.
- REQ-028: op=100, shamt=11: d_out=8'hCD -> d_next=8'hF9; d_out=8'h19 -> d_next=8'h03.
- REQ-029: With d_out=8'h19: op=000 -> 8'h19; op=110 -> 8'h19; op=010 with shamt=00 -> 8'h19.
- REQ-030: With the macro defined, reset=1 for one edge -> d_next=8'h00; then op=001, d_in=8'hDC -> d_next=8'hDC one clk edge later.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared constants for the cc_logic shifter: op codes and field widths.
package cc_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned SHAMT_W = 2;

  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
  localparam logic [OP_W-1:0] OP_LSL  = 3'b010;
  localparam logic [OP_W-1:0] OP_LSR  = 3'b011;
  localparam logic [OP_W-1:0] OP_ASR  = 3'b100;

endpackage : cc_pkg

// File: rtl/cc_shift_unit.sv
// Combinational barrel shifter used by cc_logic.
// Ports:
//   dir_right - 1: shift right, 0: shift left
//   arith     - on a right shift, fill with data MSB instead of zeros
//   shamt     - shift amount 0..3
//   data      - value to shift
//   result_c  - shifted value; bits shifted out are discarded
module cc_shift_unit
  import cc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               dir_right,
  input  logic               arith,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data,
  output logic [WIDTH-1:0]   result_c
);

  logic               fill;
  logic [2*WIDTH-1:0] ext;
  logic [2*WIDTH-1:0] ext_shr;
  logic [WIDTH-1:0]   shl;

  // Right shifts run on a double-width value whose upper half holds the fill bit.
  assign fill    = arith & data[WIDTH-1];
  assign ext     = {{WIDTH{fill}}, data};
  assign ext_shr = ext >> shamt;
  assign shl     = data << shamt;

  assign result_c = dir_right ? ext_shr[WIDTH-1:0] : shl;

endmodule : cc_shift_unit

// File: rtl/cc_logic.sv
// Next-value logic for a shift register: NOP / LOAD / LSL / LSR / ASR.
// Configuration macro: CC_LOGIC_REG_OUT_EN
//   undefined - d_next is purely combinational; clk and reset are unused.
//   defined   - d_next is registered (1-cycle latency), synchronous
//               active-high reset clears it to zero.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset (registered mode only)
//   op     - operation code (see cc_pkg)
//   shamt  - shift amount 0..3
//   d_in   - parallel load data
//   d_out  - current shifter register value
//   d_next - next register value
module cc_logic
  import cc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [WIDTH-1:0]   d_out,
  output logic [WIDTH-1:0]   d_next
);

  logic             dir_right_c;
  logic             arith_c;
  logic [WIDTH-1:0] shifted_c;
  logic [WIDTH-1:0] result_c;

  // Shift control decode.
  assign dir_right_c = (op == OP_LSR) || (op == OP_ASR);
  assign arith_c     = (op == OP_ASR);

  cc_shift_unit #(
    .WIDTH (WIDTH)
  ) u_shift (
    .dir_right (dir_right_c),
    .arith     (arith_c),
    .shamt     (shamt),
    .data      (d_out),
    .result_c  (shifted_c)
  );

  // Op select; reserved codes hold the current value.
  always_comb begin
    result_c = d_out;
    case (op)
      OP_NOP:                  result_c = d_out;
      OP_LOAD:                 result_c = d_in;
      OP_LSL, OP_LSR, OP_ASR:  result_c = shifted_c;
      default:                 result_c = d_out;
    endcase
  end

`ifdef CC_LOGIC_REG_OUT_EN
  // Output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_next <= '0;
    end else begin
      d_next <= result_c;
    end
  end
`else
  logic unused_ports_c;

  // clk and reset are kept on the port list but do not affect the output.
  assign unused_ports_c = clk ^ reset;
  assign d_next         = result_c;
`endif

endmodule : cc_logic

// File: tb/tb_cc_logic.sv
// Scoreboard bench for cc_logic: stimulus pushes expected values from an
// arithmetic reference model; a monitor pops and compares on the falling edge.
module tb_cc_logic;

  localparam int W = 8;
`ifdef CC_LOGIC_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic         clk;
  logic         reset;
  logic [2:0]   op;
  logic [1:0]   shamt;
  logic [W-1:0] d_in;
  logic [W-1:0] d_out;
  logic [W-1:0] d_next;

  typedef struct {
    logic [W-1:0] exp;
    string        name;
  } item_t;

  item_t q[$];
  int    n_cmp;
  int    n_err;
  bit    stim_done;

  cc_logic #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .op     (op),
    .shamt  (shamt),
    .d_in   (d_in),
    .d_out  (d_out),
    .d_next (d_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: shifts as multiply / floor-divide by a power of two.
  function automatic logic [W-1:0] model(int o, int s, int din, int dout);
    int p;
    int v;
    p = 1 << s;
    case (o)
      1: return W'(din);
      2: return W'((dout * p) % (1 << W));
      3: return W'(dout / p);
      4: begin
        v = (dout >= (1 << (W - 1))) ? dout - (1 << W) : dout;
        if (v >= 0) v = v / p;
        else        v = -((-v + p - 1) / p);
        return W'(v & ((1 << W) - 1));
      end
      default: return W'(dout);
    endcase
  endfunction

  task automatic issue(input bit r, input int o, input int s,
                       input int din, input int dout, input string nm);
    item_t it;
    @(posedge clk);
    #1;
    reset = r;
    op    = 3'(o);
    shamt = 2'(s);
    d_in  = W'(din);
    d_out = W'(dout);
    if (r && LAT == 1) it.exp = '0;
    else               it.exp = model(o, s, din, dout);
    it.name = nm;
    q.push_back(it);
  endtask

  // Monitor: with registered output, the oldest entry is due one edge later.
  always @(negedge clk) begin
    item_t it;
    if (q.size() > LAT || (stim_done && q.size() > 0)) begin
      it = q.pop_front();
      n_cmp++;
      if (d_next !== it.exp) begin
        n_err++;
        $display("FAIL %s: d_next=%h required=%h", it.name, d_next, it.exp);
      end
    end
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    stim_done = 1'b0;
    reset     = 1'b1;
    op        = 3'b000;
    shamt     = 2'b00;
    d_in      = '0;
    d_out     = '0;

    issue(1, 3, 1, 8'hAA, 8'hCD, "reset");
    issue(0, 1, 1, 8'h5C, 8'h00, "load_5c");
    issue(0, 2, 2, 8'h00, 8'h4D, "lsl_4d");
    issue(0, 2, 2, 8'h00, 8'h8C, "lsl_8c");
    issue(0, 3, 1, 8'h00, 8'hCD, "lsr_cd");
    issue(0, 3, 1, 8'h00, 8'h53, "lsr_53");
    issue(0, 4, 3, 8'h00, 8'hCD, "asr_cd");
    issue(0, 4, 3, 8'h00, 8'h19, "asr_19");
    issue(0, 0, 2, 8'hFF, 8'h19, "nop_19");
    issue(0, 6, 3, 8'hFF, 8'h19, "rsvd_19");
    issue(0, 2, 0, 8'hFF, 8'h19, "lsl0_19");
    issue(0, 4, 0, 8'h00, 8'h80, "asr0_80");
    issue(0, 5, 1, 8'h12, 8'h81, "rsvd5_81");
    issue(0, 7, 2, 8'h34, 8'hF0, "rsvd7_f0");
    issue(1, 2, 1, 8'h00, 8'h7F, "reset_mid");
    issue(0, 1, 0, 8'hDC, 8'h00, "load_dc");
    issue(0, 4, 3, 8'h00, 8'h80, "asr3_80");
    issue(0, 2, 3, 8'h00, 8'hFF, "lsl3_ff");

    for (int i = 0; i < 400; i++) begin
      issue(($urandom_range(0, 19) == 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), "random");
    end

    @(posedge clk);
    #1;
    stim_done = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_cc_logic
